// File: rtl/mic_array_rx_pkg.sv
// Shared types and constants for the I2S microphone-array capture front end.
// The legality check is evaluated at elaboration by the top level.
package mic_rx_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    localparam int FRAME_W = 16;

    function automatic bit params_ok(input int wl, input int slot, input int out_w,
                                     input int num, input int stereo);
        return (wl >= 8) && (wl <= slot - 1) && (out_w >= wl) && (num >= 1) &&
               (stereo == 0 || stereo == 1);
    endfunction

endpackage

// File: rtl/mic_array_rx_if.sv
// Output word stream of the microphone-array receiver: one valid/ready beat
// carries every lane of one left or right word.
interface mic_array_rx_if #(
    parameter int OUT_W = 32,
    parameter int NUM   = 8
) ();
    import mic_rx_pkg::*;

    logic                   m_valid;
    logic                   m_ready;
    logic [OUT_W*NUM-1:0]   m_data;
    chan_t                  m_chan;
    logic [FRAME_W-1:0]     m_frame;

    modport master (output m_valid, m_data, m_chan, m_frame, input m_ready);
    modport slave  (input m_valid, m_data, m_chan, m_frame, output m_ready);

endinterface

// File: rtl/mic_array_rx_lane.sv
// One serial data line: MSB-first shift register with sign extension of the
// captured word to the output lane width.
module mic_rx_lane #(
    parameter int WL    = 24,
    parameter int OUT_W = 32
) (
    input  logic             aud_bclk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sdata,
    output logic [OUT_W-1:0] word
);

    logic [WL-1:0] sr;

    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[WL-2:0], sdata};
        end
    end

    assign word = OUT_W'(signed'(sr));

endmodule

// File: rtl/mic_array_rx.sv
// I2S capture for NUM microphone lines: generates word select, deserialises
// each half-frame and hands words out through a one-entry valid/ready register.
module mic_array_rx
    import mic_rx_pkg::*;
#(
    parameter int WL     = 24,
    parameter int SLOT   = 32,
    parameter int NUM    = 8,
    parameter int STEREO = 1,
    parameter int OUT_W  = 32
) (
    input  logic            aud_bclk,
    input  logic            rst,
    input  logic            en,
    input  logic [NUM-1:0]  aud_adcdat,
    output logic            aud_lrc,
    mic_array_rx_if.master  m_if,
    output logic            overrun,
    input  logic            clr_overrun
);

    localparam int CNT_W = $clog2(2 * SLOT);

    if (!params_ok(WL, SLOT, OUT_W, NUM, STEREO)) begin : g_bad_params
        $error("mic_array_rx: illegal WL/SLOT/OUT_W/NUM/STEREO combination");
    end

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [CNT_W-1:0]     b;
    logic                 h;
    logic                 run;
    logic                 shift_en;
    logic                 done;
    logic                 done_h;
    logic [FRAME_W-1:0]   frame_nxt;
    logic [OUT_W*NUM-1:0] lanes;

    assign h        = (cnt >= CNT_W'(SLOT));
    assign b        = h ? cnt - CNT_W'(SLOT) : cnt;
    assign shift_en = en && (b >= CNT_W'(1)) && (b <= CNT_W'(WL));

    // The first enabled edge only arms the counter, so cnt = 0 is a full cycle.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (!run || cnt == CNT_W'(2 * SLOT - 1)) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            run     <= 1'b0;
            aud_lrc <= 1'b0;
            done    <= 1'b0;
            done_h  <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            run     <= 1'b0;
            aud_lrc <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            run     <= 1'b1;
            aud_lrc <= (cnt_nxt < CNT_W'(SLOT));
            done    <= (b == CNT_W'(WL)) && (!h || STEREO != 0);
            done_h  <= h;
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        mic_rx_lane #(
            .WL    (WL),
            .OUT_W (OUT_W)
        ) u_lane (
            .aud_bclk (aud_bclk),
            .rst      (rst),
            .shift_en (shift_en),
            .sdata    (aud_adcdat[i]),
            .word     (lanes[i*OUT_W +: OUT_W])
        );
    end

    // frame_nxt is the index the next left word will carry; a right word
    // always follows its own left word, hence frame_nxt - 1.
    always_ff @(posedge aud_bclk or posedge rst) begin
        if (rst) begin
            m_if.m_valid <= 1'b0;
            m_if.m_data  <= '0;
            m_if.m_chan  <= CH_LEFT;
            m_if.m_frame <= '0;
            frame_nxt    <= '0;
            overrun      <= 1'b0;
        end else begin
            if (done && (!m_if.m_valid || m_if.m_ready)) begin
                m_if.m_valid <= 1'b1;
                m_if.m_data  <= lanes;
                m_if.m_chan  <= done_h ? CH_RIGHT : CH_LEFT;
                m_if.m_frame <= done_h ? frame_nxt - FRAME_W'(1) : frame_nxt;
            end else if (m_if.m_valid && m_if.m_ready) begin
                m_if.m_valid <= 1'b0;
            end
            if (done && !done_h) begin
                frame_nxt <= frame_nxt + FRAME_W'(1);
            end
            if (done && m_if.m_valid && !m_if.m_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mic_array_rx.sv
// Directed bench for mic_array_rx: default stereo, mono and a small 4-lane
// configuration share the bit clock; expected words are written out by hand.
module tb_mic_array_rx;
    import mic_rx_pkg::*;

    typedef struct {
        logic [255:0] d;
        int           ch;
        int           fr;
        int           cn;
        int           cy;
    } rec_t;

    logic       aud_bclk = 1'b0;
    logic       rst      = 1'b0;
    logic       en       = 1'b0;
    logic       clr_st   = 1'b0;
    logic [7:0] adc24    = '0;
    logic [3:0] adc16    = '0;
    logic       lrc_st, lrc_mo, lrc_sm;
    logic       ovr_st, ovr_mo, ovr_sm;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   bcnt = 0;
    int   scnt = 0;
    bit   brun = 0;
    bit   srun = 0;
    bit   log_on = 0;
    rec_t st_q[$];
    rec_t mo_q[$];
    rec_t sm_q[$];

    logic [23:0] lw [8] = '{24'h800001, 24'h123456, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hC00000};
    logic [23:0] rw [8] = '{24'h7FFFFF, 24'hABCDEF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h3FFFFF};
    logic [15:0] sl [4] = '{16'h8001, 16'h7FFF, 16'h1234, 16'hFEDC};
    logic [15:0] sr [4] = '{16'h00FF, 16'hFF00, 16'hA5A5, 16'h5A5A};

    mic_array_rx_if #(.OUT_W(32), .NUM(8)) st_if ();
    mic_array_rx_if #(.OUT_W(32), .NUM(8)) mo_if ();
    mic_array_rx_if #(.OUT_W(16), .NUM(4)) sm_if ();

    mic_array_rx #(.WL(24), .SLOT(32), .NUM(8), .STEREO(1), .OUT_W(32)) u_st (
        .aud_bclk (aud_bclk), .rst (rst), .en (en), .aud_adcdat (adc24),
        .aud_lrc (lrc_st), .m_if (st_if), .overrun (ovr_st), .clr_overrun (clr_st)
    );

    mic_array_rx #(.WL(24), .SLOT(32), .NUM(8), .STEREO(0), .OUT_W(32)) u_mo (
        .aud_bclk (aud_bclk), .rst (rst), .en (en), .aud_adcdat (adc24),
        .aud_lrc (lrc_mo), .m_if (mo_if), .overrun (ovr_mo), .clr_overrun (1'b0)
    );

    mic_array_rx #(.WL(16), .SLOT(18), .NUM(4), .STEREO(1), .OUT_W(16)) u_sm (
        .aud_bclk (aud_bclk), .rst (rst), .en (en), .aud_adcdat (adc16),
        .aud_lrc (lrc_sm), .m_if (sm_if), .overrun (ovr_sm), .clr_overrun (1'b0)
    );

    always #5 aud_bclk = ~aud_bclk;

    // Reference bit position of each configuration, as seen by the microphones.
    always @(posedge aud_bclk or posedge rst) begin
        cyc++;
        if (rst || !en) begin
            bcnt = 0; brun = 0; scnt = 0; srun = 0;
        end else begin
            bcnt = brun ? (bcnt + 1) % 64 : 0;
            scnt = srun ? (scnt + 1) % 36 : 0;
            brun = 1;
            srun = 1;
        end
    end

    always @(negedge aud_bclk) begin
        int b;
        int s;
        b = bcnt % 32;
        s = scnt % 18;
        for (int i = 0; i < 8; i++)
            adc24[i] = (b >= 1 && b <= 24) ? (bcnt < 32 ? lw[i][24-b] : rw[i][24-b]) : 1'($urandom);
        for (int i = 0; i < 4; i++)
            adc16[i] = (s >= 1 && s <= 16) ? (scnt < 18 ? sl[i][16-s] : sr[i][16-s]) : 1'($urandom);
    end

    always @(negedge aud_bclk) begin
        if (log_on) begin
            if (st_if.m_valid && st_if.m_ready)
                st_q.push_back('{st_if.m_data, int'(st_if.m_chan), int'(st_if.m_frame), bcnt, cyc});
            if (mo_if.m_valid && mo_if.m_ready)
                mo_q.push_back('{mo_if.m_data, int'(mo_if.m_chan), int'(mo_if.m_frame), bcnt, cyc});
            if (sm_if.m_valid && sm_if.m_ready)
                sm_q.push_back('{256'(sm_if.m_data), int'(sm_if.m_chan), int'(sm_if.m_frame), scnt, cyc});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit e, input bit rdy);
        rst = 1'b1;
        @(negedge aud_bclk);
        rst = 1'b0;
        en = e;
        st_if.m_ready = rdy;
    endtask

    task automatic waitCnt(input int c);
        int n = 0;
        do begin
            @(negedge aud_bclk);
            n++;
        end while (bcnt != c && n < 300);
        if (bcnt != c) checkOutput("wait_cnt", 64'(bcnt), 64'(c));
    endtask

    task automatic waitValid();
        int n = 0;
        while (!st_if.m_valid && n < 300) begin
            @(negedge aud_bclk);
            n++;
        end
        checkOutput("wait_valid", 64'(st_if.m_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen_lrc;
        int seen_v;
        st_if.m_ready = 1'b1;
        mo_if.m_ready = 1'b1;
        sm_if.m_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge aud_bclk);
        checkOutput("rst_valid", 64'(st_if.m_valid), 64'd0);
        checkOutput("rst_data", 64'(st_if.m_data[31:0]), 64'd0);
        checkOutput("rst_frame", 64'(st_if.m_frame), 64'd0);
        checkOutput("rst_lrc", 64'(lrc_st), 64'd0);
        checkOutput("rst_ovr", 64'(ovr_st), 64'd0);
        checkOutput("rst_sm_valid", 64'(sm_if.m_valid), 64'd0);
        rst = 1'b0;

        // Three full frames with everything accepting.
        @(negedge aud_bclk);
        log_on = 1;
        en = 1'b1;
        repeat (192) @(negedge aud_bclk);
        log_on = 0;
        en = 1'b0;
        checkOutput("st_count", 64'(st_q.size()), 64'd6);
        checkOutput("st_l_lane0", 64'(st_q[0].d[31:0]), 64'hFF800001);
        checkOutput("st_l_lane1", 64'(st_q[0].d[63:32]), 64'h00123456);
        checkOutput("st_l_lane7", 64'(st_q[0].d[255:224]), 64'hFFC00000);
        checkOutput("st_l_chan", 64'(st_q[0].ch), 64'd0);
        checkOutput("st_l_frame", 64'(st_q[0].fr), 64'd0);
        checkOutput("st_l_latency", 64'(st_q[0].cn), 64'd26);
        checkOutput("st_r_lane0", 64'(st_q[1].d[31:0]), 64'h007FFFFF);
        checkOutput("st_r_lane1", 64'(st_q[1].d[63:32]), 64'hFFABCDEF);
        checkOutput("st_r_lane7", 64'(st_q[1].d[255:224]), 64'h003FFFFF);
        checkOutput("st_r_chan", 64'(st_q[1].ch), 64'd1);
        checkOutput("st_r_frame", 64'(st_q[1].fr), 64'd0);
        checkOutput("st_r_latency", 64'(st_q[1].cn), 64'd58);
        checkOutput("st_f2_r_frame", 64'(st_q[5].fr), 64'd2);
        checkOutput("mono_count", 64'(mo_q.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("mono_frame%0d", k), 64'(mo_q[k].fr), 64'(k));
            checkOutput($sformatf("mono_chan%0d", k), 64'(mo_q[k].ch), 64'd0);
        end
        checkOutput("mono_lane0", 64'(mo_q[2].d[31:0]), 64'hFF800001);
        checkOutput("sm_left", sm_q[0].d[63:0], 64'hFEDC12347FFF8001);
        checkOutput("sm_right", sm_q[1].d[63:0], 64'h5A5AA5A5FF0000FF);
        checkOutput("sm_r_chan", 64'(sm_q[1].ch), 64'd1);
        checkOutput("sm_latency", 64'(sm_q[0].cn), 64'd18);
        checkOutput("sm_period", 64'(sm_q[2].cy - sm_q[0].cy), 64'd36);

        // Overrun: downstream stalls across the right completion.
        applyStimulus(1'b1, 1'b0);
        waitCnt(57);
        checkOutput("ovr_before", 64'(ovr_st), 64'd0);
        waitCnt(58);
        checkOutput("ovr_set", 64'(ovr_st), 64'd1);
        checkOutput("ovr_hold_data", 64'(st_if.m_data[31:0]), 64'hFF800001);
        checkOutput("ovr_hold_chan", 64'(st_if.m_chan), 64'd0);
        waitCnt(60);
        clr_st = 1'b1;
        waitCnt(61);
        clr_st = 1'b0;
        checkOutput("ovr_cleared", 64'(ovr_st), 64'd0);
        waitCnt(25);
        clr_st = 1'b1;
        waitCnt(26);
        clr_st = 1'b0;
        checkOutput("ovr_clr_vs_drop", 64'(ovr_st), 64'd1);
        checkOutput("ovr_hold_frame", 64'(st_if.m_frame), 64'd0);
        st_if.m_ready = 1'b1;
        waitCnt(27);
        checkOutput("accept_clears_valid", 64'(st_if.m_valid), 64'd0);
        waitCnt(58);
        checkOutput("after_drop_frame", 64'(st_if.m_frame), 64'd1);
        checkOutput("after_drop_chan", 64'(st_if.m_chan), 64'd1);
        checkOutput("after_drop_data", 64'(st_if.m_data[31:0]), 64'h007FFFFF);

        // Enable dropped in the middle of the left half.
        applyStimulus(1'b1, 1'b1);
        waitCnt(5);
        checkOutput("lrc_left", 64'(lrc_st), 64'd1);
        waitCnt(10);
        en = 1'b0;
        seen_lrc = 0;
        seen_v = 0;
        repeat (20) begin
            @(negedge aud_bclk);
            if (lrc_st !== 1'b0) seen_lrc++;
            if (st_if.m_valid !== 1'b0) seen_v++;
        end
        checkOutput("dis_lrc", 64'(seen_lrc), 64'd0);
        checkOutput("dis_valid", 64'(seen_v), 64'd0);
        en = 1'b1;
        waitValid();
        checkOutput("reen_data", 64'(st_if.m_data[31:0]), 64'hFF800001);
        checkOutput("reen_frame", 64'(st_if.m_frame), 64'd0);
        checkOutput("reen_latency", 64'(bcnt), 64'd26);

        // Reset while a right word of frame 1 is held.
        applyStimulus(1'b1, 1'b1);
        waitCnt(58);
        waitCnt(58);
        st_if.m_ready = 1'b0;
        waitCnt(10);
        checkOutput("pre_rst_valid", 64'(st_if.m_valid), 64'd1);
        checkOutput("pre_rst_frame", 64'(st_if.m_frame), 64'd1);
        checkOutput("pre_rst_lrc", 64'(lrc_st), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(st_if.m_valid), 64'd0);
        checkOutput("arst_data", 64'(st_if.m_data[31:0]), 64'd0);
        checkOutput("arst_chan", 64'(st_if.m_chan), 64'd0);
        checkOutput("arst_frame", 64'(st_if.m_frame), 64'd0);
        checkOutput("arst_lrc", 64'(lrc_st), 64'd0);
        @(negedge aud_bclk);
        rst = 1'b0;
        st_if.m_ready = 1'b1;
        waitValid();
        checkOutput("post_rst_data", 64'(st_if.m_data[31:0]), 64'hFF800001);
        checkOutput("post_rst_chan", 64'(st_if.m_chan), 64'd0);
        checkOutput("post_rst_frame", 64'(st_if.m_frame), 64'd0);
        checkOutput("post_rst_latency", 64'(bcnt), 64'd26);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
